regfile_wb_arbiter: RTL

//  Shares the register file's single write port between two writeback sources:
//  src0 (ALU) and src1 (load/store unit).
//  - Arbitrates round-robin and registers the winner into a one-deep output stage.
//  - The output stage drives the register file's reg_write / rd / write_data.
//  - Provides forwarding-hit flags for rs1/rs2 against the in-flight write.

---
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ===========================================================================
// regfile_wb_arbiter : round-robin share of the register-file write port
//   between ALU (src0) and LSU (src1), with a one-deep output stage.
// Revision 1.0
// ===========================================================================
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_valid_i,
  input  logic [AW-1:0]    s0_rd_i,
  input  logic [XLEN-1:0]  s0_data_i,
  output logic             s0_ready_o,
  input  logic             s1_valid_i,
  input  logic [AW-1:0]    s1_rd_i,
  input  logic [XLEN-1:0]  s1_data_i,
  output logic             s1_ready_o,
  output logic             rf_we_o,
  output logic [AW-1:0]    rf_rd_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  input  logic [AW-1:0]    rs1_i,
  input  logic [AW-1:0]    rs2_i,
  output logic             fwd1_hit_o,
  output logic             fwd2_hit_o,
  output logic [XLEN-1:0]  fwd_data_o,
  output logic [CNT_W-1:0] wr_count_o
);

  // prio_q=1 means src1 wins a tie (src0 was granted most recently)
  logic             prio_q,     prio_d;
  logic             rf_we_q,    rf_we_d;
  logic [AW-1:0]    rf_rd_q,    rf_rd_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic             gnt0, gnt1;

  // Grants are suppressed while reset is asserted so no transfer can be seen.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (s0_valid_i && (!s1_valid_i || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (s1_valid_i) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d     = prio_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    wr_count_d = wr_count_q;
    if (gnt0) begin
      prio_d     = 1'b1;
      rf_rd_d    = s0_rd_i;
      rf_wdata_d = s0_data_i;
      rf_we_d    = (s0_rd_i != '0);
    end else if (gnt1) begin
      prio_d     = 1'b0;
      rf_rd_d    = s1_rd_i;
      rf_wdata_d = s1_data_i;
      rf_we_d    = (s1_rd_i != '0);
    end
    if (rf_we_d) begin
      wr_count_d = wr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      wr_count_q <= '0;
    end else begin
      prio_q     <= prio_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign s0_ready_o = gnt0;
  assign s1_ready_o = gnt1;
  assign rf_we_o    = rf_we_q;
  assign rf_rd_o    = rf_rd_q;
  assign rf_wdata_o = rf_wdata_q;
  assign wr_count_o = wr_count_q;

  // Bypass is driven only from registered state; x0 never forwards.
  assign fwd1_hit_o = rf_we_q && (rf_rd_q == rs1_i) && (rs1_i != '0);
  assign fwd2_hit_o = rf_we_q && (rf_rd_q == rs2_i) && (rs2_i != '0);
  assign fwd_data_o = rf_wdata_q;

endmodule
`default_nettype wire
